// File: rtl/booth_divider.sv
// Sequential radix-2 restoring divider producing one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module booth_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q, d, r;
   logic [WIDTH-1:0] q_step, r_step;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   trial;
   logic [CW-1:0]    cnt;
`ifdef DIVIDER_SIGNED_EN
   logic             neg_q, neg_r;
`endif

   // A restore only happens when the shifted value is below D, so it fits in WIDTH bits.
   always_comb begin
      trial = {r, q[WIDTH-1]} - {1'b0, d};
      if (trial[WIDTH]) begin
         r_step = {r[WIDTH-2:0], q[WIDTH-1]};
         q_step = {q[WIDTH-2:0], 1'b0};
      end else begin
         r_step = trial[WIDTH-1:0];
         q_step = {q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
`ifdef DIVIDER_SIGNED_EN
      dvd_mag = dividend[WIDTH-1] ? '0 - dividend : dividend;
      dvs_mag = divisor[WIDTH-1]  ? '0 - divisor  : divisor;
`else
      dvd_mag = dividend;
      dvs_mag = divisor;
`endif
   end

   // busy/done are registered from the state, so they trail it by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         q           <= '0;
         d           <= '0;
         r           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         busy <= (state == ITER) || (state == FIX);
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     q     <= dvd_mag;
                     d     <= dvs_mag;
                     r     <= '0;
                     cnt   <= '0;
`ifdef DIVIDER_SIGNED_EN
                     neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     neg_r <= dividend[WIDTH-1];
`endif
                     state <= ITER;
                  end
               end
            end
            ITER: begin
               q   <= q_step;
               r   <= r_step;
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= FIX;
            end
            FIX: begin
`ifdef DIVIDER_SIGNED_EN
               quotient  <= neg_q ? '0 - q : q;
               remainder <= neg_r ? '0 - r : r;
`else
               quotient  <= q;
               remainder <= r;
`endif
               div_by_zero <= 1'b0;
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: arithmetic reference model checked every cycle plus literal vectors.
// Follows DIVIDER_SIGNED_EN the same way the design does.
module tb_booth_divider;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] quotient, remainder;
   logic             busy, done, div_by_zero;

   booth_divider #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             z;
   } res_t;

   // Plain integer division; SV '/' and '%' truncate toward zero with remainder sign of dividend.
   function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      res_t res;
      int a, b, qi, ri;
`ifdef DIVIDER_SIGNED_EN
      a = $signed(x);
      b = $signed(y);
`else
      a = int'(x);
      b = int'(y);
`endif
      if (b == 0) begin
         res.q = '1;
         res.r = x;
         res.z = 1'b1;
      end else begin
         qi = a / b;
         ri = a % b;
         res.q = qi[WIDTH-1:0];
         res.r = ri[WIDTH-1:0];
         res.z = 1'b0;
      end
      return res;
   endfunction

   // Cycle-level expectations kept as edge numbers rather than states.
   int               edge_n = 0;
   int               free_at = 0;
   int               busy_from = -1, busy_to = -2, done_at = -1, upd_at = -1;
   logic [WIDTH-1:0] pq = '0, pr = '0, eq = '0, er = '0;
   logic             pz = 1'b0, ez = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   logic             primed = 1'b0;

   always @(posedge clk) begin
      res_t m;
      edge_n <= edge_n + 1;
      primed <= 1'b1;
      if (reset) begin
         free_at   <= edge_n + 1;
         busy_from <= -1;
         busy_to   <= -2;
         done_at   <= -1;
         upd_at    <= -1;
         eq        <= '0;
         er        <= '0;
         ez        <= 1'b0;
         e_busy    <= 1'b0;
         e_done    <= 1'b0;
      end else begin
         e_busy <= (edge_n >= busy_from) && (edge_n <= busy_to);
         e_done <= (edge_n == done_at);
         if (edge_n == upd_at) begin
            eq <= pq;
            er <= pr;
            ez <= pz;
         end
         if (start && edge_n >= free_at) begin
            m = model(dividend, divisor);
            if (m.z) begin
               eq      <= m.q;
               er      <= m.r;
               ez      <= 1'b1;
               done_at <= edge_n + 1;
               free_at <= edge_n + 2;
            end else begin
               pq        <= m.q;
               pr        <= m.r;
               pz        <= 1'b0;
               upd_at    <= edge_n + WIDTH + 1;
               busy_from <= edge_n + 1;
               busy_to   <= edge_n + WIDTH + 1;
               done_at   <= edge_n + WIDTH + 2;
               free_at   <= edge_n + WIDTH + 3;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (primed) begin
         n_checks++;
         if ({busy, done, quotient, remainder, div_by_zero} === {e_busy, e_done, eq, er, ez})
            n_pass++;
         else
            $display("FAIL cycle t=%0t: got busy=%b done=%b q=%h r=%h dz=%b, expected busy=%b done=%b q=%h r=%h dz=%b",
                     $time, busy, done, quotient, remainder, div_by_zero, e_busy, e_done, eq, er, ez);
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
   endtask

   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cycles++;
         if (done) break;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic run_lit(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int eq_l, input int er_l, input int ez_l, input int elat);
      int lat, bc;
      start_op(a, b);
      wait_done(lat, bc);
      check({name, "_q"}, int'(quotient), eq_l);
      check({name, "_r"}, int'(remainder), er_l);
      check({name, "_dz"}, int'(div_by_zero), ez_l);
      check({name, "_lat"}, lat, elat);
   endtask

   initial begin
      int lat, bc, dcount;
      repeat (3) @(negedge clk);
      check("reset_q", int'(quotient), 0);
      check("reset_busy_done", int'({busy, done, div_by_zero}), 0);
      reset = 1'b0;
      @(negedge clk);

      start_op(8'd100, 8'd7);
      wait_done(lat, bc);
      check("d100_7_q", int'(quotient), 'h0E);
      check("d100_7_r", int'(remainder), 'h02);
      check("d100_7_dz", int'(div_by_zero), 0);
      check("d100_7_lat", lat, 10);
      check("d100_7_busy", bc, 9);

      run_lit("d5_0", 8'd5, 8'd0, 'hFF, 'h05, 1, 1);
      run_lit("d9_3", 8'd9, 8'd3, 3, 0, 0, 10);
      run_lit("d255_255", 8'hFF, 8'hFF, 1, 0, 0, 10);
`ifdef DIVIDER_SIGNED_EN
      run_lit("dm100_7", 8'h9C, 8'd7, 'hF2, 'hFE, 0, 10);
      run_lit("d100_m7", 8'd100, 8'hF9, 'hF2, 'h02, 0, 10);
      run_lit("dmin_m1", 8'h80, 8'hFF, 'h80, 'h00, 0, 10);
`else
      run_lit("d200_3", 8'hC8, 8'd3, 'h42, 'h02, 0, 10);
      run_lit("d156_7", 8'h9C, 8'd7, 'h16, 'h02, 0, 10);
      run_lit("d128_255", 8'h80, 8'hFF, 'h00, 'h80, 0, 10);
`endif

      // starts at relative edges 3 and 5 fall inside the busy window
      start_op(8'd50, 8'd5);
      @(negedge clk);
      start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      check("ignored_q", int'(quotient), 10);
      check("ignored_r", int'(remainder), 0);

      start_op(8'd50, 8'd5);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_outputs", int'({quotient, remainder}), 0);
      check("abort_flags", int'({busy, done, div_by_zero}), 0);
      reset = 1'b0;
      dcount = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", dcount, 0);

      // start held high: back-to-back accepts on every return to idle
      start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      repeat (30) @(negedge clk);
      divisor = 8'd0;
      repeat (6) @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         logic [WIDTH-1:0] a, b;
         a = WIDTH'($urandom);
         b = (i == 3) ? '0 : WIDTH'($urandom);
         start_op(a, b);
         wait_done(lat, bc);
      end

      run_lit("recover_9_3", 8'd9, 8'd3, 3, 0, 0, 10);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential radix-2 restoring divider, the inverse companion to the team's Booth multiplier in the 8-bit ALU.
- Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Contains its own control FSM, so the ALU top only drives start and consumes done.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, two's complement (signed build)
divisor  input  WIDTH  denominator, two's complement (signed build)
quotient  output  WIDTH  result, registered, held until next accepted start
remainder  output  WIDTH  result, registered, held until next accepted start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse, results valid in the same cycle
div_by_zero  output  1  registered flag, valid with done, held with results

Behaviour:
- Clock is clk. Reset is synchronous and active-high (port reset). On reset: state=IDLE; quotient, remainder, busy, done, div_by_zero all 0; iteration counter 0.
- States:
  - IDLE -> ITER when start=1 and divisor!=0.
  - IDLE -> DONE when start=1 and divisor==0.
  - ITER -> ITER for WIDTH cycles, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE (single cycle).
- Accept (IDLE, start=1):
  - Latch |dividend| into Q, |divisor| into D, and the two sign bits.
  - Clear the partial remainder R (WIDTH+1 bits) and the counter.
- ITER, one cycle per bit:
  - {R,Q} <<= 1.
  - T = R - {0,D}, computed WIDTH+1 bits wide.
  - If T[WIDTH]==0: R=T, Q[0]=1; else R unchanged, Q[0]=0.
  - Counter increments; leave ITER when counter == WIDTH-1 at the edge.
- FIX:
  - quotient = Q negated if the sign bits differ.
  - remainder = R[WIDTH-1:0] negated if the dividend was negative.
  - Quotient truncates toward zero; a nonzero remainder takes the sign of the dividend.
- DONE: done=1, busy=0.
- Latency: done is high in the cycle following edge k+WIDTH+2, where edge k accepted start (10 edges for WIDTH=8). Divide-by-zero: done follows edge k+1.
- busy=1 in ITER and FIX. busy=0 in IDLE and DONE.
- Divide by zero: quotient = all ones, remainder = dividend unmodified, div_by_zero=1. Otherwise div_by_zero=0.
- Most-negative / -1 (signed): quotient wraps to most-negative (0x80 for WIDTH=8), remainder 0, no flag.
- Boundary rules:
  - start while busy or in DONE: ignored, no queuing.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - Operand inputs are don't-care except at the accept edge.
  - reset during any state: abort, return to IDLE, outputs cleared on that edge. reset has priority over start.

Optional Feature:
- Macro DIVIDER_SIGNED_EN.
- Defined: signed two's-complement division as described above (magnitude conversion, FIX sign correction).
- Undefined: operands are unsigned. Magnitude conversion and sign correction are removed. FIX only copies Q/R to the outputs. The most-negative/-1 rule does not apply.
- Latency, handshake and divide-by-zero behaviour are identical in both builds.

Test Plan:
- Signed build, WIDTH=8, dividend=100, divisor=7, start 1 cycle -> done 10 edges later; quotient=0x0E, remainder=0x02, div_by_zero=0; busy high for exactly 9 cycles.
- Signed: dividend=-100 (0x9C), divisor=7 -> quotient=0xF2 (-14), remainder=0xFE (-2). Also dividend=100, divisor=-7 -> quotient=0xF2, remainder=0x02.
- dividend=5, divisor=0 -> done on the cycle after the accept edge; quotient=0xFF, remainder=0x05, div_by_zero=1. A following 9/3 clears the flag: quotient=3, remainder=0.
- Signed: dividend=0x80, divisor=0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0.
- Start 50/5. Pulse start with 9/2 at edges 3 and 5 -> both ignored, result 10 r0. Then start 50/5 again and assert reset at edge 4 -> next cycle state IDLE, busy=0, done=0, outputs 0, no done pulse.
- Unsigned build: dividend=200 (0xC8), divisor=3 -> quotient=66 (0x42), remainder=2. dividend=255, divisor=255 -> quotient=1, remainder=0.
